// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared fetch-stage definitions: reset vector, FSM encoding and bus constants.
package inst_fetch_ctrl_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;

    localparam logic [ADDR_W-1:0] RESET_PC  = 32'hBFC0_0000;
    localparam logic [1:0]        SIZE_WORD = 2'b10;
    localparam logic [ADDR_W-1:0] PC_STEP   = 32'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_e;

    // Sequential PC; the adder wraps modulo 2^32 by construction.
    function automatic logic [ADDR_W-1:0] seq_pc(input logic [ADDR_W-1:0] pc);
        return ADDR_W'(pc + PC_STEP);
    endfunction

endpackage

// File: rtl/inst_fetch_ctrl_if.sv
// SRAM-like instruction port between the fetch controller and the CPU-to-AXI bridge.
interface inst_fetch_ctrl_if;
    import inst_fetch_ctrl_pkg::*;

    logic              inst_req;
    logic              inst_wr;
    logic [1:0]        inst_size;
    logic [ADDR_W-1:0] inst_addr;
    logic [STRB_W-1:0] inst_wstrb;
    logic [DATA_W-1:0] inst_wdata;
    logic              inst_addr_ok;
    logic              inst_data_ok;
    logic [DATA_W-1:0] inst_rdata;

    modport master (
        output inst_req, inst_wr, inst_size, inst_addr, inst_wstrb, inst_wdata,
        input  inst_addr_ok, inst_data_ok, inst_rdata
    );

    modport slave (
        input  inst_req, inst_wr, inst_size, inst_addr, inst_wstrb, inst_wdata,
        output inst_addr_ok, inst_data_ok, inst_rdata
    );

endinterface

// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch controller: owns the fetch PC, issues one read at a time to the
// bridge and hands words to decode, honouring branch delay slots and flushes.
module inst_fetch_ctrl
    import inst_fetch_ctrl_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC_P = RESET_PC
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ds_allowin,
    input  logic                    br_taken,
    input  logic [ADDR_W-1:0]       br_target,
    input  logic                    flush,
    input  logic [ADDR_W-1:0]       flush_target,
    output logic                    fs_to_ds_valid,
    output logic [ADDR_W-1:0]       fs_pc,
    output logic [DATA_W-1:0]       fs_inst,
    inst_fetch_ctrl_if.master       bus
);

    fetch_state_e      state;
    fetch_state_e      state_nxt;

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] next_pc;
    logic [ADDR_W-1:0] br_tgt_q;
    logic [ADDR_W-1:0] redir_tgt;
    logic [DATA_W-1:0] inst_buf;
    logic              cancel;
    logic              br_pend;
    logic              redir_pend;

    logic              word_ready;
    logic              handoff;

    // A word is on offer when fresh, uncancelled data arrives or one is parked in HOLD.
    always_comb begin
        word_ready = 1'b0;
        if (state == HOLD) begin
            word_ready = 1'b1;
        end else if (state == WAIT && bus.inst_data_ok && !cancel) begin
            word_ready = 1'b1;
        end
        handoff = word_ready && ds_allowin && !flush;
    end

    // A same-cycle branch means the word being handed off is its delay slot.
    always_comb begin
        if (br_taken) begin
            next_pc = br_target;
        end else if (br_pend) begin
            next_pc = br_tgt_q;
        end else begin
            next_pc = seq_pc(fetch_pc);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: state_nxt = REQ;
            REQ: begin
                if (bus.inst_addr_ok) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (bus.inst_data_ok) begin
                    if (flush || cancel || ds_allowin) begin
                        state_nxt = REQ;
                    end else begin
                        state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (flush || ds_allowin) begin
                    state_nxt = REQ;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Pending branch target; a flush discards it, a handoff consumes it.
    always_ff @(posedge clk) begin
        if (reset) begin
            br_pend  <= 1'b0;
            br_tgt_q <= '0;
        end else if (flush || handoff) begin
            br_pend  <= 1'b0;
        end else if (br_taken) begin
            br_pend  <= 1'b1;
            br_tgt_q <= br_target;
        end
    end

    // Fetch PC, cancel tracking and the redirect held while a request is unaccepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc   <= RESET_PC_P;
            cancel     <= 1'b0;
            redir_pend <= 1'b0;
            redir_tgt  <= '0;
            inst_buf   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (flush) begin
                        fetch_pc <= flush_target;
                    end
                end
                REQ: begin
                    if (bus.inst_addr_ok) begin
                        if (flush) begin
                            cancel   <= 1'b1;
                            fetch_pc <= flush_target;
                        end else if (redir_pend) begin
                            cancel   <= 1'b1;
                            fetch_pc <= redir_tgt;
                        end
                        redir_pend <= 1'b0;
                    end else if (flush) begin
                        redir_pend <= 1'b1;
                        redir_tgt  <= flush_target;
                    end
                end
                WAIT: begin
                    if (flush) begin
                        fetch_pc <= flush_target;
                        cancel   <= !bus.inst_data_ok;
                    end else if (bus.inst_data_ok) begin
                        if (cancel) begin
                            cancel <= 1'b0;
                        end else if (ds_allowin) begin
                            fetch_pc <= next_pc;
                        end else begin
                            inst_buf <= bus.inst_rdata;
                        end
                    end
                end
                HOLD: begin
                    if (flush) begin
                        fetch_pc <= flush_target;
                    end else if (ds_allowin) begin
                        fetch_pc <= next_pc;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output decode; reset forces the idle presentation regardless of state.
    always_comb begin
        fs_to_ds_valid = 1'b0;
        fs_inst        = '0;
        fs_pc          = fetch_pc;
        bus.inst_req   = 1'b0;
        bus.inst_addr  = fetch_pc;
        if (reset) begin
            fs_pc         = RESET_PC_P;
            bus.inst_addr = RESET_PC_P;
        end else begin
            case (state)
                REQ: bus.inst_req = 1'b1;
                WAIT: begin
                    fs_to_ds_valid = word_ready && !flush;
                    fs_inst        = bus.inst_rdata;
                end
                HOLD: begin
                    fs_to_ds_valid = !flush;
                    fs_inst        = inst_buf;
                end
                default: ;
            endcase
        end
    end

    assign bus.inst_wr    = 1'b0;
    assign bus.inst_size  = SIZE_WORD;
    assign bus.inst_wstrb = '0;
    assign bus.inst_wdata = '0;

endmodule
